// File: rtl/serp_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serp_seq_pkg
// Description : Shared types and constants for the serpentine chain
//               sequencer: FSM state encoding, default fill/flush lengths
//               and the stage-index width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package serp_seq_pkg;

  localparam logic [2:0] c_st_idle   = 3'd0;
  localparam logic [2:0] c_st_select = 3'd1;
  localparam logic [2:0] c_st_fill   = 3'd2;
  localparam logic [2:0] c_st_dwell  = 3'd3;
  localparam logic [2:0] c_st_flush  = 3'd4;
  localparam logic [2:0] c_st_done   = 3'd5;

  typedef enum logic [2:0] {
    IDLE   = c_st_idle,
    SELECT = c_st_select,
    FILL   = c_st_fill,
    DWELL  = c_st_dwell,
    FLUSH  = c_st_flush,
    DONE   = c_st_done
  } state_t;

  localparam int c_fill_cycles_def  = 8;
  localparam int c_flush_cycles_def = 16;

  // Stage index must also represent N_STAGES (the "whole chain" marker).
  function automatic int idx_w(input int n_stages);
    return $clog2(n_stages + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/serp_dwell_timer.sv
`default_nettype none
// ============================================================================
// Module      : serp_dwell_timer
// Description : Loadable down-counter shared by the fill, dwell and flush
//               phases. Load value-1 to time value cycles; zero flags the
//               final cycle of the phase. Saturates at zero (never wraps).
// Revision    : 1.0 - initial release
// ============================================================================
module serp_dwell_timer
  import serp_seq_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             zero
);

  logic [CNT_W-1:0] r_cnt;

  // Reload on request, otherwise count down and park at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= value;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/serpentine_chain_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : serpentine_chain_sequencer
// Description : Per job, fills each enabled serpentine stage in order
//               (valve + pump), holds its dwell, then flushes the whole
//               chain. Abort jumps straight to a full-length flush.
// Revision    : 1.0 - initial release
// ============================================================================
module serpentine_chain_sequencer
  import serp_seq_pkg::*;
#(
  parameter int N_STAGES     = 4,
  parameter int CNT_W        = 16,
  parameter int FILL_CYCLES  = c_fill_cycles_def,
  parameter int FLUSH_CYCLES = c_flush_cycles_def
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_valid,
  output logic                         start_ready,
  input  logic [N_STAGES*CNT_W-1:0]    dwell_cfg,
  input  logic [N_STAGES-1:0]          skip_mask,
  input  logic                         abort,
  output logic [N_STAGES-1:0]          valve_en,
  output logic                         pump_en,
  output logic [idx_w(N_STAGES)-1:0]   stage_idx,
  output logic                         busy,
  output logic                         done,
  output logic                         aborted
);

  localparam int               IDX_W      = idx_w(N_STAGES);
  localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(N_STAGES);
  localparam logic [CNT_W-1:0] c_fill_ld  = CNT_W'(FILL_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_flush_ld = CNT_W'(FLUSH_CYCLES - 1);

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [IDX_W-1:0]          r_idx;
  logic [IDX_W-1:0]          w_idx_nxt;
  logic                      r_abort_seen;
  logic                      w_abort_seen_nxt;
  logic [N_STAGES*CNT_W-1:0] r_dwell;
  logic [N_STAGES-1:0]       r_skip;
  logic [CNT_W-1:0]          w_dwell_cur;
  logic                      w_skip_cur;
  logic [CNT_W-1:0]          w_load_val;
  logic                      w_load;
  logic                      w_zero;
  logic                      w_accept;
  logic                      w_abort_hit;
  logic [N_STAGES-1:0]       w_valve_sel;

  assign start_ready = (r_state == IDLE);
  assign w_accept    = start_valid & start_ready;
  assign w_abort_hit = abort & (r_state inside {SELECT, FILL, DWELL});
  assign stage_idx   = r_idx;

  serp_dwell_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (w_load),
    .value (w_load_val),
    .zero  (w_zero)
  );

  // Job configuration is captured once at accept and held for the whole job.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dwell <= '0;
      r_skip  <= '0;
    end else if (w_accept) begin
      r_dwell <= dwell_cfg;
      r_skip  <= skip_mask;
    end
  end

  // Look up dwell and skip bit of the current stage (nothing matches at N_STAGES).
  always_comb begin
    w_dwell_cur = '0;
    w_skip_cur  = 1'b0;
    for (int i = 0; i < N_STAGES; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_dwell_cur = r_dwell[i*CNT_W +: CNT_W];
        w_skip_cur  = r_skip[i];
      end
    end
  end

  // Next-state, stage index, abort flag and timer load decisions.
  always_comb begin
    w_state_nxt      = r_state;
    w_idx_nxt        = r_idx;
    w_abort_seen_nxt = r_abort_seen;
    w_load           = 1'b0;
    w_load_val       = '0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt      = SELECT;
          w_idx_nxt        = '0;
          w_abort_seen_nxt = 1'b0;
        end
      end
      SELECT: begin
        if (r_idx == c_idx_last) begin
          w_state_nxt = FLUSH;
          w_load      = 1'b1;
          w_load_val  = c_flush_ld;
        end else if (w_skip_cur) begin
          w_idx_nxt = r_idx + IDX_W'(1);
        end else begin
          w_state_nxt = FILL;
          w_load      = 1'b1;
          w_load_val  = c_fill_ld;
        end
      end
      FILL: begin
        if (w_zero) begin
          if (w_dwell_cur == '0) begin
            w_state_nxt = SELECT;
            w_idx_nxt   = r_idx + IDX_W'(1);
          end else begin
            w_state_nxt = DWELL;
            w_load      = 1'b1;
            w_load_val  = w_dwell_cur - CNT_W'(1);
          end
        end
      end
      DWELL: begin
        if (w_zero) begin
          w_state_nxt = SELECT;
          w_idx_nxt   = r_idx + IDX_W'(1);
        end
      end
      FLUSH: begin
        if (w_zero) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_state_nxt      = IDLE;
        w_idx_nxt        = '0;
        w_abort_seen_nxt = 1'b0;
      end
      default: begin
        w_state_nxt = IDLE;
        w_idx_nxt   = '0;
      end
    endcase

    // Abort pre-empts any fill-phase decision; the flush always runs in full.
    if (w_abort_hit) begin
      w_state_nxt      = FLUSH;
      w_abort_seen_nxt = 1'b1;
      w_load           = 1'b1;
      w_load_val       = c_flush_ld;
    end

    // FLUSH and DONE report the whole chain.
    if (w_state_nxt == FLUSH) begin
      w_idx_nxt = c_idx_last;
    end
  end

  // One-hot valve for the stage about to be filled.
  always_comb begin
    w_valve_sel = '0;
    for (int i = 0; i < N_STAGES; i++) begin
      w_valve_sel[i] = (w_idx_nxt == IDX_W'(i));
    end
  end

  // State and registered outputs, all derived from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_abort_seen <= 1'b0;
      valve_en     <= '0;
      pump_en      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      aborted      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_abort_seen <= w_abort_seen_nxt;
      valve_en     <= (w_state_nxt == FLUSH) ? {N_STAGES{1'b1}} :
                      (w_state_nxt == FILL)  ? w_valve_sel      : '0;
      pump_en      <= (w_state_nxt == FILL) || (w_state_nxt == FLUSH);
      busy         <= (w_state_nxt != IDLE);
      done         <= (w_state_nxt == DONE);
      aborted      <= (w_state_nxt == DONE) && w_abort_seen_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serpentine_chain_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_serpentine_chain_sequencer
// Description : Self-checking bench. Expected per-cycle outputs of each job
//               are built as a timeline of phases from the job's settings.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serpentine_chain_sequencer;

  localparam int N   = 4;
  localparam int CW  = 16;
  localparam int FC  = 8;
  localparam int FLC = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_valid;
  logic          start_ready;
  logic [N*CW-1:0] dwell_cfg;
  logic [N-1:0]  skip_mask;
  logic          abort;
  logic [N-1:0]  valve_en;
  logic          pump_en;
  logic [2:0]    stage_idx;
  logic          busy;
  logic          done;
  logic          aborted;

  always #5 clk = ~clk;

  serpentine_chain_sequencer #(
    .N_STAGES     (N),
    .CNT_W        (CW),
    .FILL_CYCLES  (FC),
    .FLUSH_CYCLES (FLC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .dwell_cfg   (dwell_cfg),
    .skip_mask   (skip_mask),
    .abort       (abort),
    .valve_en    (valve_en),
    .pump_en     (pump_en),
    .stage_idx   (stage_idx),
    .busy        (busy),
    .done        (done),
    .aborted     (aborted)
  );

  typedef struct packed {
    logic [3:0] valve;
    logic       pump;
    logic [2:0] idx;
    logic       busy;
    logic       done;
    logic       aborted;
    logic       stg;     // cycle belongs to the abortable part of the job
  } ent_t;

  ent_t       exp_q[$];
  int         job_dwell[N];
  logic [N-1:0] job_mask;
  int         n_chk  = 0;
  int         n_pass = 0;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
  endtask

  function automatic ent_t mk(input logic [3:0] v, input logic p, input int idx,
                              input logic b, input logic d, input logic a, input logic s);
    ent_t e;
    e.valve = v; e.pump = p; e.idx = 3'(idx);
    e.busy = b; e.done = d; e.aborted = a; e.stg = s;
    return e;
  endfunction

  // Timeline of a job: entry j is the expected output during cycle j+1 after accept.
  task automatic build_model(input int ab_j);
    logic ab;
    exp_q.delete();
    for (int s = 0; s < N; s++) begin
      exp_q.push_back(mk(4'h0, 1'b0, s, 1'b1, 1'b0, 1'b0, 1'b1));
      if (!job_mask[s]) begin
        repeat (FC) exp_q.push_back(mk(4'(1 << s), 1'b1, s, 1'b1, 1'b0, 1'b0, 1'b1));
        repeat (job_dwell[s]) exp_q.push_back(mk(4'h0, 1'b0, s, 1'b1, 1'b0, 1'b0, 1'b1));
      end
    end
    exp_q.push_back(mk(4'h0, 1'b0, N, 1'b1, 1'b0, 1'b0, 1'b1));
    ab = 1'b0;
    if (ab_j >= 0 && ab_j < exp_q.size()) begin
      if (exp_q[ab_j].stg) begin
        while (exp_q.size() > ab_j + 1) void'(exp_q.pop_back());
        ab = 1'b1;
      end
    end
    repeat (FLC) exp_q.push_back(mk(4'hF, 1'b1, N, 1'b1, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(4'h0, 1'b0, N, 1'b1, 1'b1, ab, 1'b0));
    exp_q.push_back(mk(4'h0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic run_job(input int job, input int ab_j, input bit hold);
    ent_t e;
    build_model(ab_j);
    @(negedge clk);
    check_val($sformatf("job%0d ready", job), 16'(start_ready), 16'(1));
    start_valid = 1'b1;
    for (int i = 0; i < N; i++) dwell_cfg[i*CW +: CW] = CW'(job_dwell[i]);
    skip_mask = job_mask;
    for (int j = 0; j < exp_q.size(); j++) begin
      @(negedge clk);
      e = exp_q[j];
      check_val($sformatf("job%0d cyc%0d", job, j + 1),
                16'({start_ready, busy, done, aborted, pump_en, stage_idx, valve_en}),
                16'({~e.busy, e.busy, e.done, e.aborted, e.pump, e.idx, e.valve}));
      start_valid = hold && (j != exp_q.size() - 1);
      dwell_cfg   = {$urandom, $urandom};
      skip_mask   = 4'($urandom);
      abort       = (j == ab_j);
    end
    abort = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start_valid = 1'b0; abort = 1'b0; dwell_cfg = '0; skip_mask = '0;
    @(negedge clk);
    check_val("reset outs",
              16'({start_ready, busy, done, aborted, pump_en, stage_idx, valve_en}),
              16'({1'b1, 11'b0}));
    rst = 1'b0;

    // All stages, dwell 5: stages 1..56, flush 58..73, done at 74.
    for (int i = 0; i < N; i++) job_dwell[i] = 5;
    job_mask = 4'b0000;
    run_job(1, -1, 1'b1);

    // Stages 1 and 3 skipped, zero dwell.
    for (int i = 0; i < N; i++) job_dwell[i] = 0;
    job_mask = 4'b1010;
    run_job(2, -1, 1'b0);

    // Every stage skipped.
    job_mask = 4'b1111;
    run_job(3, -1, 1'b1);

    // Abort in stage 2 dwell, then abort during flush.
    for (int i = 0; i < N; i++) job_dwell[i] = 5;
    job_mask = 4'b0000;
    run_job(4, 38, 1'b0);
    run_job(5, 60, 1'b1);

    // Single-cycle dwells.
    for (int i = 0; i < N; i++) job_dwell[i] = 1;
    run_job(6, -1, 1'b0);

    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < N; i++) job_dwell[i] = $urandom_range(0, 4);
      job_mask = 4'($urandom);
      run_job(10 + k, ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 60)),
              1'($urandom));
    end

    // Asynchronous reset in the middle of a fill.
    @(negedge clk);
    for (int i = 0; i < N; i++) dwell_cfg[i*CW +: CW] = 16'd3;
    skip_mask   = 4'b0000;
    start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_val("prerst valve", 16'({pump_en, valve_en}), 16'({1'b1, 4'b0001}));
    #2 rst = 1'b1;
    #1 check_val("async rst outs", 16'({start_ready, busy, pump_en, valve_en}), 16'({1'b1, 1'b0, 1'b0, 4'b0000}));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_val("post rst idle", 16'({start_ready, busy, done, stage_idx}), 16'({1'b1, 1'b0, 1'b0, 3'd0}));

    for (int i = 0; i < N; i++) job_dwell[i] = 2;
    job_mask = 4'b0100;
    run_job(99, -1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
